// File: rtl/iic_reg16_master.sv
// Byte-level I2C master: one register transaction per trigger (8-bit device id, 16-bit register address, one data byte).
// Optional build macro IIC_CLK_STRETCH_EN: when defined, the master waits on scl_in at q2 so a slave can stretch the clock.
module iic_reg16_master #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int SCL_FREQ = 400_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  device_id,
    input  logic        iic_trig,
    input  logic        w_r,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic [7:0]  data_out,
    output logic        byte_over,
    output logic        ack_err,
    output logic        scl_oe,
    input  logic        scl_in,
    output logic        sda_oe,
    input  logic        sda_in
);

    localparam int QDIV_CALC = CLK_FREQ / (4 * SCL_FREQ);
    localparam int QDIV      = (QDIV_CALC < 2) ? 2 : QDIV_CALC;
    localparam int QW        = $clog2(QDIV);
    localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_START   = 4'd1,
        S_DEV_W   = 4'd2,
        S_ADDR_H  = 4'd3,
        S_ADDR_L  = 4'd4,
        S_WR_DATA = 4'd5,
        S_RSTART  = 4'd6,
        S_DEV_R   = 4'd7,
        S_RD_DATA = 4'd8,
        S_STOP    = 4'd9
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [QW-1:0]   r_qcnt;
    logic [1:0]      r_quarter;
    logic [2:0]      r_bit;
    logic            r_ack_ph;
    logic            r_ack_bit;
    logic [7:0]      r_shift;
    logic [6:0]      r_dev;
    logic            r_wr;
    logic [15:0]     r_addr;
    logic [7:0]      r_wdata;

    logic            w_accept;
    logic            w_qend;
    logic            w_hold;
    logic            w_qtick;
    logic            w_bit_end;
    logic            w_sample;
    logic            w_is_byte;
    logic            w_byte_end;
    logic            w_scl_oe;
    logic            w_sda_oe;
    logic [1:0]      w_unused_bits;

    function automatic logic is_byte_state(input state_t st);
        case (st)
            S_DEV_W, S_ADDR_H, S_ADDR_L, S_WR_DATA, S_DEV_R, S_RD_DATA: is_byte_state = 1'b1;
            default:                                                   is_byte_state = 1'b0;
        endcase
    endfunction

    // Byte the master shifts out in a given state; 0xFF keeps SDA released while reading.
    function automatic logic [7:0] tx_byte(input state_t st, input logic [6:0] dev,
                                           input logic [15:0] a, input logic [7:0] d);
        case (st)
            S_DEV_W:   tx_byte = {dev, 1'b0};
            S_ADDR_H:  tx_byte = a[15:8];
            S_ADDR_L:  tx_byte = a[7:0];
            S_WR_DATA: tx_byte = d;
            S_DEV_R:   tx_byte = {dev, 1'b1};
            default:   tx_byte = 8'hFF;
        endcase
    endfunction

    assign w_unused_bits = {device_id[0], scl_in};

    assign w_accept = (r_state == S_IDLE) && !busy && iic_trig;
    assign w_qend   = (r_qcnt == QLAST);
`ifdef IIC_CLK_STRETCH_EN
    assign w_hold   = (r_quarter == 2'd2) && w_qend && !scl_in;
`else
    assign w_hold   = 1'b0;
`endif
    assign w_qtick    = w_qend && !w_hold && (r_state != S_IDLE);
    assign w_bit_end  = w_qtick && (r_quarter == 2'd3);
    assign w_sample   = w_qtick && (r_quarter == 2'd2);
    assign w_is_byte  = is_byte_state(r_state);
    assign w_byte_end = w_bit_end && w_is_byte && r_ack_ph;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and bus-line decode per state and quarter
    always_comb begin
        w_state_nx = r_state;
        w_scl_oe   = 1'b0;
        w_sda_oe   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = S_START;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_START: begin
                w_scl_oe = (r_quarter == 2'd3);
                w_sda_oe = (r_quarter != 2'd0);
                if (w_bit_end) begin
                    w_state_nx = S_DEV_W;
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_DEV_W, S_ADDR_H, S_ADDR_L, S_WR_DATA, S_DEV_R, S_RD_DATA: begin
                w_scl_oe = (r_quarter[1] == 1'b0);
                if (r_ack_ph || (r_state == S_RD_DATA)) begin
                    w_sda_oe = 1'b0;
                end else begin
                    w_sda_oe = ~r_shift[7];
                end
                if (!w_byte_end) begin
                    w_state_nx = r_state;
                end else if (r_ack_bit && (r_state != S_RD_DATA)) begin
                    w_state_nx = S_STOP;
                end else begin
                    case (r_state)
                        S_DEV_W:  w_state_nx = S_ADDR_H;
                        S_ADDR_H: w_state_nx = S_ADDR_L;
                        S_ADDR_L: w_state_nx = r_wr ? S_WR_DATA : S_RSTART;
                        S_DEV_R:  w_state_nx = S_RD_DATA;
                        default:  w_state_nx = S_STOP;
                    endcase
                end
            end
            S_RSTART: begin
                // Release SDA while SCL is low, raise SCL, then pull SDA low with SCL high
                w_scl_oe = (r_quarter == 2'd0) || (r_quarter == 2'd3);
                w_sda_oe = r_quarter[1];
                if (w_bit_end) begin
                    w_state_nx = S_DEV_R;
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_STOP: begin
                w_scl_oe = (r_quarter == 2'd0);
                w_sda_oe = (r_quarter[1] == 1'b0);
                if (w_bit_end) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = r_state;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Quarter timing, shift/bit counters, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_qcnt    <= '0;
            r_quarter <= 2'd0;
            r_bit     <= 3'd0;
            r_ack_ph  <= 1'b0;
            r_ack_bit <= 1'b0;
            r_shift   <= 8'h00;
            r_dev     <= 7'h00;
            r_wr      <= 1'b0;
            r_addr    <= 16'h0000;
            r_wdata   <= 8'h00;
            busy      <= 1'b0;
            byte_over <= 1'b0;
            data_out  <= 8'h00;
            ack_err   <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            byte_over <= 1'b0;
            scl_oe    <= w_scl_oe;
            sda_oe    <= w_sda_oe;
            if (w_accept) begin
                r_dev     <= device_id[7:1];
                r_wr      <= w_r;
                r_addr    <= addr;
                r_wdata   <= data_in;
                busy      <= 1'b1;
                ack_err   <= 1'b0;
                r_qcnt    <= '0;
                r_quarter <= 2'd0;
                r_bit     <= 3'd0;
                r_ack_ph  <= 1'b0;
                r_ack_bit <= 1'b0;
            end else begin
                if (r_state == S_IDLE) begin
                    r_qcnt <= '0;
                end else if (!w_hold) begin
                    r_qcnt <= w_qend ? '0 : (r_qcnt + QW'(1));
                end
                if (w_qtick) begin
                    r_quarter <= r_quarter + 2'd1;
                end
                if (w_sample) begin
                    if (r_ack_ph) begin
                        r_ack_bit <= sda_in;
                    end else if (r_state == S_RD_DATA) begin
                        r_shift <= {r_shift[6:0], sda_in};
                    end
                end
                if (w_bit_end && w_is_byte && !r_ack_ph) begin
                    if (r_state != S_RD_DATA) begin
                        r_shift <= {r_shift[6:0], 1'b1};
                    end
                    if (r_bit == 3'd7) begin
                        r_ack_ph <= 1'b1;
                        r_bit    <= 3'd0;
                    end else begin
                        r_bit <= r_bit + 3'd1;
                    end
                end
                if (w_byte_end) begin
                    r_ack_ph <= 1'b0;
                    if (r_state == S_RD_DATA) begin
                        data_out  <= r_shift;
                        byte_over <= 1'b1;
                    end else if (r_ack_bit) begin
                        ack_err <= 1'b1;
                    end else if (r_state == S_WR_DATA) begin
                        byte_over <= 1'b1;
                    end
                end
                if (w_bit_end && (w_state_nx != r_state) && is_byte_state(w_state_nx)) begin
                    r_shift <= tx_byte(w_state_nx, r_dev, r_addr, r_wdata);
                end
                if ((r_state == S_STOP) && w_bit_end) begin
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_iic_reg16_master.sv
// Bench for iic_reg16_master: an I2C bus monitor plus ACKing slave model decodes the wires,
// and each transaction is compared with the byte sequence and length derived from the protocol rules.
module tb_iic_reg16_master;

    localparam int CLK_FREQ = 8_000_000;
    localparam int SCL_FREQ = 1_000_000;
    localparam int QDIV     = CLK_FREQ / (4 * SCL_FREQ);
    localparam int BITCLK   = 4 * QDIV;
    localparam int HOLD     = 200 + 2 * QDIV;
    localparam int LIMIT    = 5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  device_id = 8'h00;
    logic        iic_trig = 1'b0;
    logic        w_r = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic        busy, byte_over, ack_err, scl_oe, sda_oe;
    logic [7:0]  data_out;
    logic        scl_in, sda_in;
    logic        slave_sda_low = 1'b0;
    logic        slave_scl_hold = 1'b0;

    assign scl_in = ~(scl_oe | slave_scl_hold);
    assign sda_in = ~(sda_oe | slave_sda_low);

    iic_reg16_master #(.CLK_FREQ(CLK_FREQ), .SCL_FREQ(SCL_FREQ)) dut (
        .clk(clk), .rst(rst), .device_id(device_id), .iic_trig(iic_trig), .w_r(w_r),
        .addr(addr), .data_in(data_in), .busy(busy), .data_out(data_out),
        .byte_over(byte_over), .ack_err(ack_err), .scl_oe(scl_oe), .scl_in(scl_in),
        .sda_oe(sda_oe), .sda_in(sda_in)
    );

    always #5 clk = ~clk;

    // slave configuration (written by the stimulus only)
    int         nack_at = -1;
    logic [7:0] rdata_s = 8'h00;
    logic       stretch_en = 1'b0;
    int         txn_id = 0;

    // monitor-owned state; log entries: -1 START, -2 STOP, else (byte<<1)|ack
    int         log_q[$];
    int         seen_id = 0;
    int         bitcnt = 0, gbyte = 0, hold_cnt = 0, bo_cnt = 0;
    logic       p_scl = 1'b1, p_sda = 1'b1, s, d;
    logic       slave_tx = 1'b0, first = 1'b0, last_ack = 1'b0, bo_busy = 1'b0;
    logic [7:0] cur = 8'h00, bo_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            slave_sda_low  = 1'b0;
            slave_scl_hold = 1'b0;
            hold_cnt = 0; bitcnt = 0; slave_tx = 1'b0;
            p_scl = 1'b1; p_sda = 1'b1;
        end else begin
            if (seen_id != txn_id) begin
                seen_id = txn_id; log_q.delete(); gbyte = 0; bo_cnt = 0;
            end
            s = scl_in; d = sda_in;
            if (byte_over === 1'b1) begin
                bo_cnt++; bo_data = data_out; bo_busy = busy;
            end
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) slave_scl_hold = 1'b0;
            end
            if (p_scl && s && p_sda && !d) begin
                log_q.push_back(-1); bitcnt = 0; slave_tx = 1'b0; slave_sda_low = 1'b0; first = 1'b1;
            end else if (p_scl && s && !p_sda && d) begin
                log_q.push_back(-2); bitcnt = 0; slave_tx = 1'b0; slave_sda_low = 1'b0;
            end else if (!p_scl && s) begin
                if (bitcnt < 8) cur = {cur[6:0], d};
                else begin
                    last_ack = d;
                    log_q.push_back(int'({cur, d}));
                end
                bitcnt++;
            end else if (p_scl && !s) begin
                if (bitcnt == 8) begin
                    if (slave_tx) slave_sda_low = 1'b0;
                    else slave_sda_low = (gbyte != nack_at);
                    if (stretch_en && gbyte == 0 && !slave_tx) begin
                        slave_scl_hold = 1'b1; hold_cnt = HOLD;
                    end
                end else if (bitcnt == 9) begin
                    if (first) slave_tx = cur[0] && !last_ack;
                    else if (slave_tx && last_ack) slave_tx = 1'b0;
                    first = 1'b0; gbyte++; bitcnt = 0;
                    slave_sda_low = slave_tx ? !rdata_s[7] : 1'b0;
                end else if (slave_tx && bitcnt >= 1 && bitcnt <= 7) begin
                    slave_sda_low = !rdata_s[7 - bitcnt];
                end
            end
            p_scl = s; p_sda = d;
        end
    end

    int         n_pass = 0, n_total = 0, n_fail = 0;
    int         exp_q[$];
    int         exp_k;
    logic [7:0] dmodel = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: bus log and byte count from the transaction rules
    task automatic build_exp(input logic wr, input logic [7:0] id, input logic [15:0] a,
                             input logic [7:0] dt, input logic [7:0] rd, input int nk);
        int b[$];
        int ack;
        exp_q.delete();
        exp_k = 0;
        b.push_back(int'(id & 8'hFE)); b.push_back(int'(a[15:8])); b.push_back(int'(a[7:0]));
        if (wr) b.push_back(int'(dt));
        else begin b.push_back(int'(id | 8'h01)); b.push_back(int'(rd)); end
        exp_q.push_back(-1);
        for (int i = 0; i < b.size(); i++) begin
            if (!wr && i == 3) exp_q.push_back(-1);
            ack = (i == nk || (!wr && i == 4)) ? 1 : 0;
            exp_q.push_back(b[i] * 2 + ack);
            exp_k++;
            if (i == nk) break;
        end
        exp_q.push_back(-2);
    endtask

    task automatic run_txn(input string nm, input logic wr, input logic [7:0] id, input logic [15:0] a,
                           input logic [7:0] dt, input logic [7:0] rd, input int nk,
                           input logic stretch, input logic disturb);
        int   cnt;
        int   exp_cyc;
        logic full;
        logic ok;
        logic [31:0] obs;
        build_exp(wr, id, a, dt, rd, nk);
        ok = !(nk >= 0 && nk <= 3);
        full = 1'b1;
        nack_at = nk; rdata_s = rd; stretch_en = stretch;
        @(negedge clk);
        txn_id++;
        device_id = id; w_r = wr; addr = a; data_in = dt; iic_trig = 1'b1;
        @(negedge clk);
        iic_trig = 1'b0;
        check({nm, " busy_after_trig"}, 32'(busy), 32'd1);
        check({nm, " ack_err_cleared"}, 32'(ack_err), 32'd0);
        cnt = 0;
        while (busy === 1'b1 && cnt < LIMIT) begin
            cnt++;
            if (disturb && cnt == 40) begin
                iic_trig = 1'b1; addr = ~a; device_id = ~id; data_in = ~dt; w_r = ~wr;
            end else begin
                iic_trig = 1'b0;
            end
            @(negedge clk);
        end
        iic_trig = 1'b0;
        exp_cyc = (2 + 9 * exp_k + ((!wr && exp_k > 3) ? 1 : 0)) * BITCLK;
        if (stretch) begin
`ifdef IIC_CLK_STRETCH_EN
            check({nm, " stretched_len"}, 32'(cnt >= exp_cyc + 196 && cnt <= exp_cyc + 204), 32'd1);
`else
            check({nm, " unstretched_len"}, 32'(cnt), 32'(exp_cyc));
            full = 1'b0;
`endif
        end else begin
            check({nm, " busy_len"}, 32'(cnt), 32'(exp_cyc));
        end
        if (full) begin
            check({nm, " log_len"}, 32'(log_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++) begin
                obs = (i < log_q.size()) ? 32'(log_q[i]) : 32'h7FFF_FFFF;
                check($sformatf("%s log[%0d]", nm, i), obs, 32'(exp_q[i]));
            end
            check({nm, " byte_over_cnt"}, 32'(bo_cnt), ok ? 32'd1 : 32'd0);
            if (ok) check({nm, " busy_at_byte_over"}, 32'(bo_busy), 32'd1);
            if (ok && !wr) begin
                check({nm, " data_at_byte_over"}, 32'(bo_data), 32'(rd));
                dmodel = rd;
            end
            check({nm, " ack_err"}, 32'(ack_err), ok ? 32'd0 : 32'd1);
            check({nm, " data_out_hold"}, 32'(data_out), 32'(dmodel));
        end
        stretch_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int w;
        logic       rw;
        logic [7:0] rid, rdt, rrd;
        logic [15:0] ra;
        int rnk;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset byte_over", 32'(byte_over), 32'd0);
        check("reset data_out", 32'(data_out), 32'h00);
        check("reset ack_err", 32'(ack_err), 32'd0);
        check("reset scl_oe", 32'(scl_oe), 32'd0);
        check("reset sda_oe", 32'(sda_oe), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_txn("wr1281", 1'b1, 8'hB2, 16'h1281, 8'h04, 8'h00, -1, 1'b0, 1'b0);
        run_txn("rd0003", 1'b0, 8'hB2, 16'h0003, 8'h00, 8'h5A, -1, 1'b0, 1'b0);
        run_txn("nack_addr_l", 1'b1, 8'hB2, 16'h4321, 8'h77, 8'h00, 2, 1'b0, 1'b0);
        run_txn("after_nack", 1'b1, 8'hB2, 16'h0102, 8'hC3, 8'h00, -1, 1'b0, 1'b0);
        run_txn("disturbed", 1'b0, 8'h6C, 16'hBEEF, 8'h11, 8'hA5, -1, 1'b0, 1'b1);

        // reset during ADDR_H
        nack_at = -1;
        @(negedge clk);
        txn_id++;
        device_id = 8'hB2; w_r = 1'b1; addr = 16'hF00D; data_in = 8'h99; iic_trig = 1'b1;
        @(negedge clk);
        iic_trig = 1'b0;
        w = 0;
        while (log_q.size() < 2 && w < 400) begin w++; @(negedge clk); end
        check("rst reached_addr_h", 32'(log_q.size() >= 2), 32'd1);
        repeat (10 + $urandom_range(0, 30)) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst scl_oe", 32'(scl_oe), 32'd0);
        check("rst sda_oe", 32'(sda_oe), 32'd0);
        dmodel = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run_txn("post_rst", 1'b0, 8'hB2, 16'h0003, 8'h00, 8'h3C, -1, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            rw  = 1'($urandom_range(0, 1));
            rid = 8'($urandom);
            ra  = 16'($urandom);
            rdt = 8'($urandom);
            rrd = 8'($urandom);
            rnk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_txn($sformatf("rand%0d", t), rw, rid, ra, rdt, rrd, rnk, 1'b0, 1'b0);
        end

        run_txn("stretch", 1'b1, 8'hB2, 16'h1281, 8'h04, 8'h00, -1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
